// File: rtl/midi_event_parser.sv
// MIDI byte-stream parser with running status, SysEx skipping, a channel window and an event FIFO.
// Define MIDI_REALTIME_EN to forward F8/FA/FB/FC real-time bytes as ev_type 7 events.
module midi_event_parser #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CHW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                          clk_sys,
  input  logic                          reset_n,
  input  logic [3:0]                    ch_base,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [2:0]                    ev_type,
  output logic [CHW-1:0]                ev_ch,
  output logic [6:0]                    ev_d1,
  output logic [6:0]                    ev_d2,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned EW = 3 + CHW + 14;
  localparam logic [AW:0] FullCnt = FIFO_DEPTH[AW:0];
  localparam logic [4:0]  NumCh5  = NUM_CH[4:0];

  typedef enum logic [1:0] {StIdle, StWaitD1, StWaitD2, StSysex} state_e;

  state_e         state_q, state_d;
  logic [2:0]     typ_q, typ_d;
  logic [CHW-1:0] ch_q, ch_d;
  logic           win_q, win_d;
  logic [6:0]     d1_q, d1_d;

  logic [EW-1:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0]  wr_q, rd_q;
  logic [AW:0]    cnt_q, cnt_d;
  logic           in_ready_q;

  logic           accept, push, push_ok, pop, full;
  logic [EW-1:0]  push_ent;
  logic [4:0]     ch_abs, ch_lo, ch_hi, ch_rel;

  assign accept = in_valid && in_ready_q;
  assign ch_abs = {1'b0, in_data[3:0]};
  assign ch_lo  = {1'b0, ch_base};
  // Window is computed in 5 bits so ch_base + NUM_CH never wraps into low channels.
  assign ch_hi  = ch_lo + NumCh5;
  assign ch_rel = ch_abs - ch_lo;

  always_comb begin
    state_d  = state_q;
    typ_d    = typ_q;
    ch_d     = ch_q;
    win_d    = win_q;
    d1_d     = d1_q;
    push     = 1'b0;
    push_ent = '0;
    if (accept) begin
      if (in_data[7]) begin
        if (in_data[7:4] != 4'hF) begin
          state_d = StWaitD1;
          typ_d   = in_data[6:4];
          win_d   = (ch_abs >= ch_lo) && (ch_abs < ch_hi);
          ch_d    = ch_rel[CHW-1:0];
        end else if (in_data == 8'hF0) begin
          state_d = StSysex;
        end else if (!in_data[3]) begin
          state_d = StIdle;
        end else begin
`ifdef MIDI_REALTIME_EN
          if (in_data == 8'hF8 || in_data == 8'hFA || in_data == 8'hFB || in_data == 8'hFC) begin
            push     = 1'b1;
            push_ent = {3'd7, {CHW{1'b0}}, in_data[6:0], 7'd0};
          end
`endif
        end
      end else begin
        case (state_q)
          StWaitD1: begin
            if (typ_q == 3'd4 || typ_q == 3'd5) begin
              push     = win_q;
              push_ent = {typ_q, ch_q, in_data[6:0], 7'd0};
            end else begin
              d1_d    = in_data[6:0];
              state_d = StWaitD2;
            end
          end
          StWaitD2: begin
            push     = win_q;
            // NoteOn with zero velocity is reported as NoteOff.
            push_ent = {(typ_q == 3'd1 && in_data[6:0] == 7'd0) ? 3'd0 : typ_q,
                        ch_q, d1_q, in_data[6:0]};
            state_d  = StWaitD1;
          end
          default: ;
        endcase
      end
    end
  end

  assign full    = (cnt_q == FullCnt);
  assign push_ok = push && !full;
  assign pop     = ev_valid && ev_ready;

  always_comb begin
    cnt_d = cnt_q;
    if (push_ok && !pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (pop && !push_ok) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      typ_q      <= '0;
      ch_q       <= '0;
      win_q      <= 1'b0;
      d1_q       <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      in_ready_q <= 1'b1;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      typ_q      <= typ_d;
      ch_q       <= ch_d;
      win_q      <= win_d;
      d1_q       <= d1_d;
      cnt_q      <= cnt_d;
      in_ready_q <= (cnt_d != FullCnt);
      if (push_ok) begin
        mem_q[wr_q] <= push_ent;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop) begin
        rd_q <= rd_q + 1'b1;
      end
    end
  end

  assign in_ready   = in_ready_q;
  assign ev_valid   = (cnt_q != '0);
  assign fifo_level = cnt_q;
  assign {ev_type, ev_ch, ev_d1, ev_d2} = mem_q[rd_q];

endmodule

// File: tb/tb_midi_event_parser.sv
// Scoreboard bench for midi_event_parser: directed byte streams, queued expected events.
module tb_midi_event_parser;

  typedef logic [18:0] ev_t;

  logic       clk_sys = 1'b0;
  logic       reset_n;
  logic [3:0] ch_base;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       ev_valid;
  logic       ev_ready;
  logic [2:0] ev_type;
  logic [1:0] ev_ch;
  logic [6:0] ev_d1;
  logic [6:0] ev_d2;
  logic [3:0] fifo_level;

  int checks = 0;
  int errors = 0;
  ev_t sb[$];

  midi_event_parser #(.NUM_CH(4), .FIFO_DEPTH(8)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ch_base(ch_base),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_type(ev_type), .ev_ch(ev_ch),
    .ev_d1(ev_d1), .ev_d2(ev_d2), .fifo_level(fifo_level)
  );

  always #5 clk_sys = ~clk_sys;

  function automatic ev_t mk(input logic [2:0] t, input logic [1:0] c,
                             input logic [6:0] a, input logic [6:0] b);
    return {t, c, a, b};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input logic [2:0] t, input logic [1:0] c,
                           input logic [6:0] a, input logic [6:0] b);
    sb.push_back(mk(t, c, a, b));
  endtask

  task automatic send(input logic [7:0] b);
    bit ok = 1'b0;
    in_data  = b;
    in_valid = 1'b1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk_sys);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: byte %0h never accepted, expected acceptance", b);
    end
    @(posedge clk_sys);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 200 && sb.size() != 0; n++) @(posedge clk_sys);
    repeat (6) @(posedge clk_sys);
    #1;
    check("drain_left", 32'(sb.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_ev_valid"}, 32'(ev_valid), 32'd0);
    check({tag, "_ev_fields"}, 32'({ev_type, ev_ch, ev_d1, ev_d2}), 32'd0);
    check({tag, "_fifo_level"}, 32'(fifo_level), 32'd0);
  endtask

  // Monitor: every pop is compared against the oldest expected event.
  always @(negedge clk_sys) begin
    if (reset_n && ev_valid && ev_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got %0h, expected none",
                 {ev_type, ev_ch, ev_d1, ev_d2});
      end else begin
        check("event", 32'({ev_type, ev_ch, ev_d1, ev_d2}), 32'(sb.pop_front()));
      end
    end
  end

  initial begin
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    ev_ready = 1'b1;
    ch_base  = 4'd0;
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    check_reset_outputs("reset");
    @(posedge clk_sys);
    #1;
    reset_n = 1'b1;

    // Running status
    expect_ev(3'd1, 2'd0, 7'h3C, 7'h64);
    expect_ev(3'd1, 2'd0, 7'h3E, 7'h50);
    send(8'h90); send(8'h3C); send(8'h64); send(8'h3E); send(8'h50);
    drain();

    // Channel window and velocity-0 NoteOn
    ch_base = 4'd2;
    expect_ev(3'd0, 2'd1, 7'h40, 7'h00);
    send(8'h91); send(8'h40); send(8'h7F);
    send(8'h93); send(8'h40); send(8'h00);
    drain();

    // Top of the channel range, and ch_base sampled at status time
    ch_base = 4'd12;
    expect_ev(3'd1, 2'd3, 7'h10, 7'h20);
    send(8'h9F); send(8'h10); send(8'h20);
    ch_base = 4'd13;
    expect_ev(3'd1, 2'd2, 7'h11, 7'h21);
    send(8'h9F); send(8'h11); send(8'h21);
    send(8'h9C); send(8'h12); send(8'h22);
    ch_base = 4'd12;
    expect_ev(3'd1, 2'd0, 7'h22, 7'h33);
    send(8'h9C);
    ch_base = 4'd0;
    send(8'h22); send(8'h33);
    drain();

    // Interleaved real-time byte
`ifdef MIDI_REALTIME_EN
    expect_ev(3'd7, 2'd0, 7'h78, 7'h00);
`endif
    expect_ev(3'd1, 2'd0, 7'h3C, 7'h64);
    send(8'h90); send(8'h3C); send(8'hF8); send(8'h64);
    drain();

    // SysEx and system-common bytes clear running status
    send(8'h90); send(8'hF0); send(8'h01); send(8'h02); send(8'hF7); send(8'h3C); send(8'h64);
    send(8'h90); send(8'hF3); send(8'h3C); send(8'h64);
    drain();

    // Single- and two-byte messages of other types
    expect_ev(3'd4, 2'd2, 7'h05, 7'h00);
    expect_ev(3'd6, 2'd0, 7'h00, 7'h40);
    send(8'hC2); send(8'h05); send(8'hE0); send(8'h00); send(8'h40);
    drain();

    // FIFO full back-pressure
    ev_ready = 1'b0;
    for (int i = 0; i < 10; i++) expect_ev(3'd1, 2'd0, 7'(8'h30 + i), 7'(8'h10 + i));
    fork
      begin
        send(8'h90);
        for (int i = 0; i < 10; i++) begin
          send(8'h30 + 8'(i));
          send(8'h10 + 8'(i));
        end
      end
      begin
        for (int n = 0; n < 300 && fifo_level != 4'd8; n++) @(negedge clk_sys);
        check("full_level", 32'(fifo_level), 32'd8);
        repeat (5) @(negedge clk_sys);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_level_hold", 32'(fifo_level), 32'd8);
        @(posedge clk_sys);
        #1;
        ev_ready = 1'b1;
        for (int n = 0; n < 50 && !in_ready; n++) @(negedge clk_sys);
        check("in_ready_back", 32'(in_ready), 32'd1);
      end
    join
    drain();

    // Reset while a message waits for its second data byte
    ev_ready = 1'b0;
    send(8'h90); send(8'h3C); send(8'h64);
    @(negedge clk_sys);
    check("pre_reset_level", 32'(fifo_level), 32'd1);
    send(8'h90); send(8'h3C);
    reset_n = 1'b0;
    @(negedge clk_sys);
    check_reset_outputs("midreset");
    @(posedge clk_sys);
    #1;
    reset_n  = 1'b1;
    ev_ready = 1'b1;
    send(8'h64);
    expect_ev(3'd0, 2'd0, 7'h3C, 7'h00);
    send(8'h80); send(8'h3C); send(8'h00);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1);
  end

endmodule
